// File: rtl/simplez_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the Simplez program loader and the program RAM.
// The master modport is the byte source and RAM/CPU observer; the loader uses the slave modport.
interface simplez_loader_if #(
    parameter int AW = 9,
    parameter int DW = 12
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          cpu_rstn;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_data, mem_we, cpu_rstn, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_data, mem_we, cpu_rstn, busy, done, err
    );
endinterface

// File: rtl/simplez_loader.sv
// Simplez program loader: frames of SYNC, LEN_H, LEN_L, then (HI,LO) word pairs written to RAM from address 0.
// Define SIMPLEZ_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (mismatch sets err).
module simplez_loader #(
    parameter int         AW   = 9,
    parameter int         DW   = 12,
    parameter logic [7:0] SYNC = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    simplez_loader_if.slave   bus
);

`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_e;
    localparam state_e FRAME_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_HI, S_LO, S_DONE
    } state_e;
    localparam state_e FRAME_END = S_DONE;
`endif

    state_e        state_q, state_d;
    logic          len_h_q, len_h_d;
    logic [3:0]    nib_q, nib_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_rstn_q, cpu_rstn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
    logic          err_q, err_d;
`endif

    logic       is_sync;
    logic [8:0] len_w;

    assign is_sync = (bus.rx_data == SYNC);
    assign len_w   = {len_h_q, bus.rx_data};

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_h_q    <= 1'b0;
            nib_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_h_q    <= len_h_d;
            nib_q      <= nib_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic: every transition is gated by a received byte
    always_comb begin
        state_d = state_q;
        if (bus.rx_valid) begin
            case (state_q)
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
                S_IDLE, S_DONE, S_ERR: if (is_sync) state_d = S_LEN_H;
                S_CHK:   state_d = (bus.rx_data == chk_q) ? S_DONE : S_ERR;
`else
                S_IDLE, S_DONE: if (is_sync) state_d = S_LEN_H;
`endif
                S_LEN_H: state_d = S_LEN_L;
                S_LEN_L: state_d = (len_w == 9'd0) ? FRAME_END : S_HI;
                S_HI:    state_d = S_LO;
                S_LO:    state_d = (cnt_q == AW'(1)) ? FRAME_END : S_HI;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_comb begin
        len_h_d    = len_h_q;
        nib_d      = nib_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        if (bus.rx_valid) begin
            case (state_q)
                S_LEN_H: len_h_d = bus.rx_data[0];
                S_LEN_L: begin
                    cnt_d = AW'(len_w);
                    ptr_d = '0;
                end
                S_HI:    nib_d = bus.rx_data[3:0];
                S_LO: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = DW'({nib_q, bus.rx_data});
                    ptr_d      = ptr_q + AW'(1);
                    cnt_d      = cnt_q - AW'(1);
                end
                default: ;
            endcase
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
            if (state_q == S_LEN_H || state_q == S_LEN_L || state_q == S_HI || state_q == S_LO)
                chk_d = chk_q ^ bus.rx_data;
            else if (state_d == S_LEN_H)
                chk_d = '0;
`endif
        end

        // done/cpu_rstn rise one cycle after DONE is entered and drop with the restarting SYNC
        busy_d     = (state_d == S_LEN_H) || (state_d == S_LEN_L) || (state_d == S_HI) ||
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
                     (state_d == S_CHK) ||
`endif
                     (state_d == S_LO);
        done_d     = (state_q == S_DONE) && (state_d == S_DONE);
        cpu_rstn_d = done_d;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
        err_d      = (state_d == S_ERR);
`endif
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.cpu_rstn = cpu_rstn_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: doc/simplez_loader.md
Name: simplez_loader

Overview:
- Program loader upstream of the Simplez CPU and its shared program/data RAM.
- Consumes bytes from the UART receiver, assembles 12-bit words and writes them sequentially into RAM from address 0.
- Holds the CPU in reset (cpu_rstn low) while loading and releases it once the load completes.
- Lets new programs be loaded without re-synthesising the ROM init file.

Parameters:
- AW, 9, RAM address width (words).
- DW, 12, RAM data width.
- SYNC, 8'h55, frame start byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- mem_addr  out  AW  RAM write address.
- mem_data  out  DW  RAM write data.
- mem_we  out  1  RAM write strobe, one cycle per word.
- cpu_rstn  out  1  active-low CPU reset; low while loading.
- busy  out  1  high from SYNC accepted until frame end.
- done  out  1  high after a successful load, until the next SYNC or reset.
- err  out  1  frame error flag (checksum feature only; tied 0 otherwise).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: mem_addr=0, mem_data=0, mem_we=0, cpu_rstn=0, busy=0, done=0, err=0; state=IDLE.
- Frame format: SYNC, LEN_H (bit0 only = len[8]; bits 7:1 ignored), LEN_L (len[7:0]), then len word pairs.
  - Each pair is HI (bits 3:0 = word[11:8]; bits 7:4 ignored) followed by LO (word[7:0]).
  - len range 0..511.
- States: IDLE, GET_LEN_H, GET_LEN_L, GET_HI, GET_LO, [GET_CHK], DONE.
- IDLE:
  - Non-SYNC bytes are ignored.
  - SYNC moves to GET_LEN_H: busy=1, done=0, err=0, cpu_rstn=0.
- GET_LEN_H and GET_LEN_L each latch one byte, then advance.
- After LEN_L:
  - len==0 goes directly to frame end (DONE, or GET_CHK with the feature enabled).
  - Otherwise go to GET_HI. The word counter loads len and the write pointer loads 0.
- GET_HI latches the nibble, then goes to GET_LO.
- On the LO byte:
  - The next cycle drives mem_we=1 with mem_addr=pointer and mem_data={nibble,LO}.
  - mem_addr/mem_data stay stable while mem_we=1; mem_we lasts exactly 1 cycle.
  - Then pointer+1 and counter-1.
  - Counter reaching 0 ends the frame; otherwise return to GET_HI.
- Write latency: mem_we asserts exactly 1 clk after the rx_valid of the LO byte.
- Pointer never wraps: len ≤ 511, so the maximum address is 510.
- DONE:
  - busy=0, done=1, cpu_rstn=1 (registered, asserted the cycle after entering DONE).
  - A further SYNC byte restarts the load: cpu_rstn=0 in the next cycle, done=0.
  - Other bytes are ignored.
- States only advance on rx_valid; no timeout. An aborted frame keeps the CPU in reset until rst.
- rx_valid coinciding with the mem_we cycle is accepted normally; the write does not stall reception.
- rst mid-frame: immediate return to reset values. Words already written stay in RAM.
- cpu_rstn is registered (glitch-free) and never high while busy=1.

Optional Feature:
- Macro: SIMPLEZ_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data byte, one extra byte CHK is expected in state GET_CHK.
  - CHK must equal the XOR of LEN_H, LEN_L and all data bytes.
  - Match: DONE with err=0.
  - Mismatch: DONE-equivalent with busy=0, done=0, err=1, cpu_rstn held 0. Only a new SYNC (restart, clears err) or rst leaves it.
  - The checksum register resets at SYNC.
- Disabled: no GET_CHK state; err is constant 0.

Test Plan:
- Reset then frame 55 00 02 0E 01 03 45 -> two mem_we pulses: addr0=0x E01, addr1=0x345. Then done=1, cpu_rstn=1, busy=0.
- Bytes 12 34 before 55 00 01 07 FF -> junk ignored, single write addr0=0x7FF.
- Frame 55 00 00 -> no mem_we, done=1 immediately after LEN_L (checksum build: after CHK=0x00).
- rst asserted after the HI byte of word 1 in a 3-word frame -> all outputs return to reset values, no further writes, cpu_rstn=0. A new full frame then loads correctly from addr 0.
- After done, send 55 00 01 0A BC -> cpu_rstn drops the cycle after SYNC, write addr0=0xABC, cpu_rstn returns to 1.
- With SIMPLEZ_LOADER_CHECKSUM_EN: frame 55 00 01 01 23 then CHK=0x23 -> done=1. Same frame with CHK=0x24 -> err=1, done=0, cpu_rstn=0.
